// File: rtl/decode_queue.sv
// decode_queue: circular fetch-to-decode instruction buffer with in-order multi-lane enqueue/dequeue.
// Define DQ_PREDECODE_EN to enable direct-branch predecode, prediction correction and front-end redirect.
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [IN_W-1:0]     in_valid,
  input  logic [IN_W*32-1:0]  in_pc,
  input  logic [IN_W*32-1:0]  in_inst,
  input  logic [IN_W-1:0]     in_pred_taken,
  input  logic [IN_W*32-1:0]  in_pred_target,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_valid,
  output logic [OUT_W*32-1:0] out_pc,
  output logic [OUT_W*32-1:0] out_inst,
  output logic [OUT_W-1:0]    out_pred_taken,
  output logic [OUT_W*32-1:0] out_pred_target,
  output logic [OUT_W-1:0]    out_fixed,
  input  logic                out_ready,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, n_in, n_out;
  logic [31:0] m_pc [DEPTH];
  logic [31:0] m_inst [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  logic [DEPTH-1:0] m_pt, m_fix;
  logic [IN_W-1:0] wr_pt, wr_fix;
  logic [31:0] wr_tgt [IN_W];
  logic enq, stop;
`ifdef DQ_PREDECODE_EN
  logic rd_hit;
  logic [31:0] rd_pc;
`endif
  assign in_ready = count <= CW'(DEPTH - IN_W);
  assign enq = in_ready && !flush && !redirect_valid;
  assign n_out = out_ready ? (count < CW'(OUT_W) ? count : CW'(OUT_W)) : '0;
  for (genvar g = 0; g < IN_W; g++) begin : g_pd
`ifdef DQ_PREDECODE_EN
    logic [31:0] pc, inst, ptgt, tgt;
    logic unc, cnd, jr, pt;
    assign pc   = in_pc[32*g+:32];
    assign inst = in_inst[32*g+:32];
    assign ptgt = in_pred_target[32*g+:32];
    assign pt   = in_pred_taken[g];
    assign unc  = inst[31:27] == 5'b01010;
    assign cnd  = inst[31:26] >= 6'h16 && inst[31:26] <= 6'h1b;
    assign jr   = inst[31:26] == 6'h13;
    assign tgt  = pc + (unc ? {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00}
                            : {{14{inst[25]}}, inst[25:10], 2'b00});
    assign wr_fix[g] = (pt && !(unc || cnd || jr)) || (pt && (unc || cnd) && ptgt != tgt) || (!pt && unc);
    assign wr_pt[g]  = wr_fix[g] ? unc : pt;
    assign wr_tgt[g] = wr_fix[g] ? (unc ? tgt : pc + 32'd4) : ptgt;
`else
    assign wr_fix[g] = 1'b0;
    assign wr_pt[g]  = in_pred_taken[g];
    assign wr_tgt[g] = in_pred_target[32*g+:32];
`endif
  end
  // A mistaken lane is kept but terminates the group, like an invalid lane does.
  always_comb begin
    n_in = '0;
    stop = 1'b0;
`ifdef DQ_PREDECODE_EN
    rd_hit = 1'b0;
    rd_pc = '0;
`endif
    for (int i = 0; i < IN_W; i++) begin
      if (enq && !stop && in_valid[i]) begin
        n_in = n_in + CW'(1);
        stop = wr_fix[i];
`ifdef DQ_PREDECODE_EN
        rd_hit = wr_fix[i];
        rd_pc = wr_tgt[i];
`endif
      end else stop = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(n_out);
      tail <= tail + PW'(n_in);
      count <= count + n_in - n_out;
    end
    for (int i = 0; i < IN_W; i++)
      if (CW'(i) < n_in) begin
        m_pc[tail + PW'(i)] <= in_pc[32*i+:32];
        m_inst[tail + PW'(i)] <= in_inst[32*i+:32];
        m_tgt[tail + PW'(i)] <= wr_tgt[i];
        m_pt[tail + PW'(i)] <= wr_pt[i];
        m_fix[tail + PW'(i)] <= wr_fix[i];
      end
  end
`ifdef DQ_PREDECODE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_valid <= rd_hit;
      if (rd_hit) redirect_pc <= rd_pc;
    end
  end
`else
  assign redirect_valid = 1'b0;
  assign redirect_pc = '0;
`endif
  for (genvar g = 0; g < OUT_W; g++) begin : g_out
    logic [PW-1:0] idx;
    assign idx = head + PW'(g);
    assign out_valid[g] = count > CW'(g);
    assign out_pc[32*g+:32] = m_pc[idx];
    assign out_inst[32*g+:32] = m_inst[idx];
    assign out_pred_target[32*g+:32] = m_tgt[idx];
    assign out_pred_taken[g] = m_pt[idx];
    assign out_fixed[g] = m_fix[idx];
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue (DEPTH=8, IN_W=2, OUT_W=2), both DQ_PREDECODE_EN builds.
module tb_decode_queue;
  localparam logic [31:0] NOP = 32'h02800000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, flush, out_ready, in_ready, redirect_valid;
  logic [1:0] in_valid, in_pred_taken, out_valid, out_pred_taken, out_fixed;
  logic [63:0] in_pc, in_inst, in_pred_target, out_pc, out_inst, out_pred_target;
  logic [31:0] redirect_pc;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic pt; logic [31:0] tgt; logic fix;} ent_t;
  ent_t sb[$];
  int checks = 0, fails = 0;
  logic exp_rv = 1'b0;
  logic [31:0] exp_rpc = '0;

  decode_queue #(.DEPTH(8), .IN_W(2), .OUT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target), .out_fixed(out_fixed), .out_ready(out_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic pt, input logic [31:0] tgt);
    ent_t e;
`ifdef DQ_PREDECODE_EN
    logic [25:0] off;
    logic [31:0] t;
    logic unc, br, jr, mis;
`endif
    e.pc = pc; e.inst = inst; e.pt = pt; e.tgt = tgt; e.fix = 1'b0;
`ifdef DQ_PREDECODE_EN
    unc = inst[31:26] inside {6'b010100, 6'b010101};
    br = unc || (inst[31:26] inside {[6'b010110:6'b011011]});
    jr = inst[31:26] == 6'b010011;
    off = unc ? {inst[9:0], inst[25:10]} : {{10{inst[25]}}, inst[25:10]};
    t = pc + ({{6{off[25]}}, off} << 2);
    mis = (pt && !br && !jr) || (pt && br && tgt != t) || (!pt && unc);
    if (mis) begin
      e.fix = 1'b1;
      e.pt = unc;
      e.tgt = unc ? t : pc + 32'd4;
    end
`endif
    return e;
  endfunction

  task automatic check_outputs();
    int n = sb.size();
    check("out_valid", 32'(out_valid), {30'd0, n > 1, n > 0});
    check("in_ready", 32'(in_ready), 32'(n <= 6));
    check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
    check("redirect_pc", redirect_pc, exp_rpc);
    for (int i = 0; i < 2 && i < n; i++) begin
      check($sformatf("pc%0d", i), out_pc[32*i+:32], sb[i].pc);
      check($sformatf("inst%0d", i), out_inst[32*i+:32], sb[i].inst);
      check($sformatf("pt%0d", i), 32'(out_pred_taken[i]), 32'(sb[i].pt));
      check($sformatf("tgt%0d", i), out_pred_target[32*i+:32], sb[i].tgt);
      check($sformatf("fixed%0d", i), 32'(out_fixed[i]), 32'(sb[i].fix));
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                     input logic [31:0] pc1, input logic [31:0] i1, input logic [1:0] pt,
                     input logic [31:0] t0, input logic [31:0] t1, input logic rdy, input logic fl);
    ent_t e[2];
    bit acc, stop, hit;
    in_valid = v; in_pc = {pc1, pc0}; in_inst = {i1, i0}; in_pred_taken = pt;
    in_pred_target = {t1, t0}; out_ready = rdy; flush = fl;
    e[0] = mk(pc0, i0, pt[0], t0);
    e[1] = mk(pc1, i1, pt[1], t1);
    hit = 0;
    if (fl) sb.delete();
    else begin
      acc = sb.size() <= 6 && !exp_rv;
      if (rdy) repeat (sb.size() < 2 ? sb.size() : 2) void'(sb.pop_front());
      stop = 0;
      if (acc)
        for (int i = 0; i < 2; i++)
          if (!stop && v[i]) begin
            sb.push_back(e[i]);
            if (e[i].fix) begin
              stop = 1; hit = 1; exp_rpc = e[i].tgt;
            end
          end else stop = 1;
    end
    exp_rv = hit;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic grp(input logic [31:0] pc, input logic rdy);
    cyc(2'b11, pc, NOP, pc + 32'd4, NOP, 2'b00, '0, '0, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy, input logic fl);
    cyc(2'b00, '0, '0, '0, '0, 2'b00, '0, '0, rdy, fl);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) grp(32'h1c000000 + 32'(8 * n), 1'b0);
    cyc(2'b11, 32'h1c000020, 32'h50000800, 32'h1c000024, NOP, 2'b00, '0, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    for (int n = 0; n < 3; n++) grp(32'h1c001000 + 32'(8 * n), 1'b0);
    grp(32'h1c001018, 1'b1);
    idle(1'b1, 1'b0);
    grp(32'h1c002000, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] p = $urandom & 32'hfffffffc;
      cyc(2'($urandom_range(0, 3)), p, NOP ^ 32'($urandom_range(0, 255)), p + 32'd4, NOP,
          2'b00, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (5) idle(1'b1, 1'b0);
    cyc(2'b11, 32'h1c000000, 32'h50000800, 32'h1c000004, NOP, 2'b00, '0, '0, 1'b0, 1'b0);
    cyc(2'b11, 32'h1c000100, NOP, 32'h1c000104, NOP, 2'b00, '0, '0, 1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    cyc(2'b01, 32'h1c000010, 32'h00100000, '0, NOP, 2'b01, 32'h1c000040, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    cyc(2'b11, 32'h1c000200, 32'h53fffbff, 32'h1c000204, NOP, 2'b00, '0, '0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    cyc(2'b11, 32'h1c000300, 32'h50000800, 32'h1c000304, NOP, 2'b01, 32'h1c000308, '0, 1'b1, 1'b0);
    cyc(2'b11, 32'h1c000400, 32'h58001000, 32'h1c000404, NOP, 2'b01, 32'h1c000500, '0, 1'b1, 1'b0);
    cyc(2'b11, 32'h1c000500, NOP, 32'h1c000504, NOP, 2'b00, '0, '0, 1'b0, 1'b1);
    repeat (3) idle(1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
